// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Holds the datapath widths, reset PC, bubble instruction, and the IF/ID record layout.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_PC  = 16'h0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [PC_W-1:0] PC_STEP = 16'd4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    // Word-align a byte address by clearing the two low bits.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with its next-PC selection.
// Selection order is reset, then redirect, then stall, then sequential advance.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [cpu_pkg::PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] pc_target,
    output logic [PC_W-1:0] pc
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= word_align(pc_target);
        end else if (!stall) begin
            pc <= pc + PC_STEP;  // wraps modulo 2^16 by width
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the PC to external instruction memory and captures
// the returned word into the IF/ID register, squashing wrong-path fetches on redirect.
module instr_fetch #(
    parameter logic [cpu_pkg::PC_W-1:0]    RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [cpu_pkg::INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        redirect,
    input  logic [cpu_pkg::PC_W-1:0]    pc_target,
    output logic [cpu_pkg::PC_W-1:0]    im_addr,
    input  logic [cpu_pkg::INSTR_W-1:0] im_data,
    output logic [cpu_pkg::PC_W-1:0]    if_pc,
    output logic [cpu_pkg::INSTR_W-1:0] if_instr,
    output logic                        if_valid,
    output logic                        misalign
);
    import cpu_pkg::*;

    logic [PC_W-1:0] pc;
    if_id_t          if_id;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .redirect  (redirect),
        .pc_target (pc_target),
        .pc        (pc)
    );

    // NOTE: reset is synchronous and checked first, so it overrides stall and
    // redirect in the same cycle and nothing pending survives across it.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id    <= '{pc: RESET_PC, instr: NOP_INSTR, valid: 1'b0};
            misalign <= 1'b0;
        end else begin
            misalign <= redirect && (pc_target[1:0] != 2'b00);
            if (redirect) begin
                // The word fetched this cycle is on the wrong path; replace it with a bubble.
                if_id <= '{pc: pc, instr: NOP_INSTR, valid: 1'b0};
            end else if (!stall) begin
                if_id <= '{pc: pc, instr: im_data, valid: 1'b1};
            end
        end
    end

    assign im_addr  = pc;
    assign if_pc    = if_id.pc;
    assign if_instr = if_id.instr;
    assign if_valid = if_id.valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: a table of per-cycle vectors followed
// by a hand-written free-run sequence after reset.
module tb_instr_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] WORD0 = 32'h0030_0413;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] pc_target = 16'h0000;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic [15:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .redirect  (redirect),
        .pc_target (pc_target),
        .im_addr   (im_addr),
        .im_data   (im_data),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_valid  (if_valid),
        .misalign  (misalign)
    );

    // Instruction memory contents: word 0 is fixed, every other word encodes its address.
    function automatic logic [31:0] mem(input logic [15:0] a);
        if (a == 16'h0000) return WORD0;
        return {16'hC0DE, a};
    endfunction

    assign im_data = mem(im_addr);

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rdr;
        logic [15:0] tgt;
        logic [15:0] e_addr;
        logic [15:0] e_pc;
        logic        e_valid;
        logic        e_mis;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic [15:0] t);
        reset     = r;
        stall     = s;
        redirect  = d;
        pc_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rst  stl  rdr  target    im_addr   if_pc     valid mis
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0041, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 16'h0004, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h000C, 16'h0008, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h000C, 16'h0008, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h000C, 16'h0008, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h000C, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0014, 16'h0010, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0044, 16'h0044, 16'h0014, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h0034, 16'h0034, 16'h0044, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0038, 16'h0034, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h003C, 16'h0038, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 16'h0036, 16'h0034, 16'h003C, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0034, 16'h003C, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0038, 16'h0034, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 16'hFFFE, 16'hFFFC, 16'h0038, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFC, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0000, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 16'h0080, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 16'h0081, 16'h0080, 16'h0000, 1'b0, 1'b1};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0004, 16'h0000, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0008, 16'h0004, 1'b1, 1'b0};

        for (int i = 0; i < NV; i++) begin
            logic [31:0] e_instr;
            step(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].tgt);
            e_instr = vecs[i].e_valid ? mem(vecs[i].e_pc) : NOP;
            check("im_addr",  i, {16'h0, im_addr},  {16'h0, vecs[i].e_addr});
            check("if_pc",    i, {16'h0, if_pc},    {16'h0, vecs[i].e_pc});
            check("if_instr", i, if_instr,          e_instr);
            check("if_valid", i, {31'h0, if_valid}, {31'h0, vecs[i].e_valid});
            check("misalign", i, {31'h0, misalign}, {31'h0, vecs[i].e_mis});
        end

        // Fresh reset held three cycles, then free-run five edges.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("rst_addr", 100, {16'h0, im_addr}, 32'h0000_0000);
        for (int i = 0; i < 5; i++) begin
            logic [15:0] e_addr;
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            e_addr = 16'(4 * (i + 1));
            check("run_addr",  200 + i, {16'h0, im_addr},  {16'h0, e_addr});
            check("run_pc",    200 + i, {16'h0, if_pc},    {16'h0, e_addr - 16'd4});
            check("run_valid", 200 + i, {31'h0, if_valid}, 32'h1);
        end
        check("run_instr0", 205, if_instr, mem(16'h0010));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), bubble instruction.
REQ-003 Port clk input 1: single clock; all state updates on rising edge.
REQ-004 Port reset input 1: synchronous, active-high reset.
REQ-005 Port stall input 1: hazard unit hold request; freezes PC and IF/ID register.
REQ-006 Port redirect input 1: taken branch/jump resolved downstream; load pc_target.
REQ-007 Port pc_target input 16: byte address of redirect destination.
REQ-008 Port im_addr output 16: byte address driven to instruction memory, equal to current PC.
REQ-009 Port im_data input 32: instruction word returned combinationally by instruction memory for im_addr.
REQ-010 Port if_pc output 16: PC of instruction held in IF/ID register.
REQ-011 Port if_instr output 32: instruction held in IF/ID register.
REQ-012 Port if_valid output 1: IF/ID register holds a real fetched instruction (0 = bubble).
REQ-013 Port misalign output 1: one-cycle pulse when an accepted redirect target has bits [1:0] != 0.

Function
REQ-014 im_addr SHALL equal the PC register combinationally; no extra latency.
REQ-015 PC update priority per edge SHALL be: reset > redirect > stall > sequential.
REQ-016 Sequential: PC <= PC + 4, modulo 2^16 (16'hFFFC wraps to 16'h0000, no flag).
REQ-017 Redirect: PC <= {pc_target[15:2], 2'b00} regardless of stall; misalign pulses next cycle iff pc_target[1:0] != 0.
REQ-018 Stall without redirect: PC, if_pc, if_instr, if_valid SHALL hold their values.
REQ-019 Normal advance: if_instr <= im_data, if_pc <= PC, if_valid <= 1 (one-cycle fetch latency).
REQ-020 On redirect: if_instr <= NOP_INSTR, if_valid <= 0, if_pc <= PC (wrong-path fetch squashed); redirect overrides simultaneous stall.
REQ-021 Consecutive redirect cycles SHALL each produce a bubble; first valid instruction appears the cycle after redirect deasserts, with if_pc = last target.
REQ-022 if_instr SHALL be NOP_INSTR whenever if_valid = 0.
REQ-023 Block SHALL not inspect or decode instruction contents.

Reset
REQ-024 On reset: PC = RESET_PC, if_pc = RESET_PC, if_instr = NOP_INSTR, if_valid = 0, misalign = 0.
REQ-025 Reset SHALL win over asserted stall/redirect in the same cycle; first valid fetch lands in IF/ID on the first edge after reset deasserts.
REQ-026 Reset mid-stall or mid-redirect SHALL discard pending state; no redirect latched across reset.

Structure
REQ-027 Shared package cpu_pkg SHALL hold PC_W (16), INSTR_W (32), NOP_INSTR, RESET_PC.
REQ-028 Sub-module pc_reg (PC register + next-PC mux) is natural; IF/ID register stays in instr_fetch.
REQ-029 Instruction memory remains external; connected only via im_addr/im_data.

Verification
REQ-030 Reset 3 cycles, release, memory word 0 = 32'h00300413 -> after 1st edge if_pc=0x0000, if_instr=32'h00300413, if_valid=1; after 2nd edge if_pc=0x0004.
REQ-031 Free-run 5 edges from reset -> im_addr sequence 0x0004,0x0008,0x000C,0x0010,0x0014; if_valid=1 throughout.
REQ-032 Stall 2 cycles while PC=0x000C -> im_addr stays 0x000C, if_pc stays 0x0008; resumes 0x0010 after release.
REQ-033 At PC=0x0044 assert redirect with pc_target=0x0034 -> next cycle im_addr=0x0034, if_valid=0, if_instr=32'h00000013; following cycle if_pc=0x0034, if_valid=1.
REQ-034 redirect and stall together, pc_target=0x0036 -> PC=0x0034, misalign=1 for exactly one cycle, bubble inserted.
REQ-035 Force PC to 0xFFFC via redirect, then free-run -> im_addr 0x0000 next; reset asserted during a redirect -> PC=0x0000, if_valid=0.
